// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the Sobel frame sequencer.
//   - one-hot FSM state encodings (S_IDLE .. S_ABORT)
//   - default sync header bytes
//   - clog2 helper used to size column, row and timeout counters
package sobel_pkg;

   localparam int NUM_ST = 5;

   // One-hot state encodings; each state owns exactly one bit.
   localparam logic [NUM_ST-1:0] S_IDLE  = 5'b00001;
   localparam logic [NUM_ST-1:0] S_HDR   = 5'b00010;
   localparam logic [NUM_ST-1:0] S_DATA  = 5'b00100;
   localparam logic [NUM_ST-1:0] S_DONE  = 5'b01000;
   localparam logic [NUM_ST-1:0] S_ABORT = 5'b10000;

   localparam logic [7:0] HDR0_DEF = 8'hAA;
   localparam logic [7:0] HDR1_DEF = 8'h55;

   // Ceiling log2, never below 1 so that every counter has at least one bit.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >>> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/sobel_pix_cnt.sv
// sobel_pix_cnt: column/row position counter for one frame.
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   clr    in   zero both counters (frame start)
//   en     in   advance one pixel position
//   col    out  current column, 0..COLS-1
//   row    out  current row, 0..ROWS-1
//   sof    out  current position is (0,0)
//   eof    out  current position is (ROWS-1,COLS-1), i.e. last pixel
module sobel_pix_cnt
   import sobel_pkg::*;
#(
   parameter int COLS = 100,
   parameter int ROWS = 100
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   output logic [clog2(COLS)-1:0]   col,
   output logic [clog2(ROWS)-1:0]   row,
   output logic                     sof,
   output logic                     eof
);

   localparam int CW = clog2(COLS);
   localparam int RW = clog2(ROWS);

   logic col_end;
   logic row_end;

   assign col_end = (col == CW'(COLS - 1));
   assign row_end = (row == RW'(ROWS - 1));
   assign sof     = (col == '0) && (row == '0);
   assign eof     = col_end && row_end;

   // Raster-order advance; the last pixel wraps both counters back to (0,0).
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sobel_frame_seq.sv
// sobel_frame_seq: frames the uart_rx byte stream for sobel_ctrl.
// Hunts for the HDR0,HDR1 sync pair, then forwards COLS*ROWS pixel bytes
// tagged with column/row and start/end-of-frame. An inter-byte gap of
// TIMEOUT cycles in DATA aborts the frame (clr pulse, err_cnt++); in HDR
// it silently returns to the hunt.
//   clk         in   system clock (s_clk)
//   rst_n       in   synchronous active-low reset
//   pi_flag     in   byte strobe from uart_rx
//   pi_data     in   received byte
//   po_flag     out  pixel strobe, one cycle after the accepting pi_flag
//   po_data     out  pixel byte
//   po_col      out  pixel column
//   po_row      out  pixel row
//   po_sof      out  with po_flag of pixel (0,0)
//   po_eof      out  with po_flag of pixel (ROWS-1,COLS-1)
//   clr         out  line-buffer flush pulse (frame start or abort)
//   busy        out  in HDR or DATA
//   frame_done  out  pulse after a complete frame
//   err_cnt     out  saturating aborted-frame count
module sobel_frame_seq
   import sobel_pkg::*;
#(
   parameter int         COLS    = 100,
   parameter int         ROWS    = 100,
   parameter logic [7:0] HDR0    = HDR0_DEF,
   parameter logic [7:0] HDR1    = HDR1_DEF,
   parameter int         TIMEOUT = 500000,
   parameter int         ERR_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pi_flag,
   input  logic [7:0]               pi_data,
   output logic                     po_flag,
   output logic [7:0]               po_data,
   output logic [clog2(COLS)-1:0]   po_col,
   output logic [clog2(ROWS)-1:0]   po_row,
   output logic                     po_sof,
   output logic                     po_eof,
   output logic                     clr,
   output logic                     busy,
   output logic                     frame_done,
   output logic [ERR_W-1:0]         err_cnt
);

   localparam int CW = clog2(COLS);
   localparam int RW = clog2(ROWS);
   localparam int TW = clog2(TIMEOUT);

   logic [NUM_ST-1:0] state;
   logic [NUM_ST-1:0] state_nx;

   logic [TW-1:0] tmo;
   logic          tmo_hit;
   logic          active;

   logic [CW-1:0] cnt_col;
   logic [RW-1:0] cnt_row;
   logic          cnt_sof;
   logic          cnt_eof;

   // Output-comb decodes, registered below.
   logic          lock;
   logic          pix_en;
   logic          clr_d;
   logic          done_d;

   assign active  = (state == S_HDR) || (state == S_DATA);
   assign tmo_hit = (tmo == TW'(TIMEOUT - 1));

   sobel_pix_cnt #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_pix_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lock),
      .en    (pix_en),
      .col   (cnt_col),
      .row   (cnt_row),
      .sof   (cnt_sof),
      .eof   (cnt_eof)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // ---------------------------------------------------------------- next state
   // A byte always beats the terminal count: pi_flag is tested first.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (pi_flag && (pi_data == HDR0)) state_nx = S_HDR;
         end
         S_HDR: begin
            if (pi_flag) begin
               if (pi_data == HDR1)      state_nx = S_DATA;
               else if (pi_data == HDR0) state_nx = S_HDR;   // repeated sync byte
               else                      state_nx = S_IDLE;
            end else if (tmo_hit) begin
               state_nx = S_IDLE;
            end
         end
         S_DATA: begin
            if (pi_flag) begin
               if (cnt_eof) state_nx = S_DONE;
            end else if (tmo_hit) begin
               state_nx = S_ABORT;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_ABORT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      lock   = (state == S_HDR) && pi_flag && (pi_data == HDR1);
      pix_en = (state == S_DATA) && pi_flag;
      clr_d  = lock || (state == S_ABORT);
      done_d = (state == S_DONE);
      busy   = active;
   end

   // Pulse outputs are registered so they land one cycle after their cause.
   // Pixel tags are captured from the counter before it advances.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         po_flag    <= 1'b0;
         po_data    <= '0;
         po_col     <= '0;
         po_row     <= '0;
         po_sof     <= 1'b0;
         po_eof     <= 1'b0;
         clr        <= 1'b0;
         frame_done <= 1'b0;
         err_cnt    <= '0;
      end else begin
         po_flag    <= pix_en;
         po_sof     <= pix_en && cnt_sof;
         po_eof     <= pix_en && cnt_eof;
         clr        <= clr_d;
         frame_done <= done_d;
         if (pix_en) begin
            po_data <= pi_data;
            po_col  <= cnt_col;
            po_row  <= cnt_row;
         end
         if ((state == S_ABORT) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- timeout
   // Idle-gap counter: cleared by every byte and every state change, and held
   // at zero outside HDR/DATA. It never passes TIMEOUT-1 since reaching it
   // without a byte forces a state change.
   always_ff @(posedge clk) begin
      if (!rst_n)                                      tmo <= '0;
      else if (pi_flag || (state_nx != state) || !active) tmo <= '0;
      else                                             tmo <= tmo + 1'b1;
   end

endmodule

// File: tb/tb_sobel_frame_seq.sv
module tb_sobel_frame_seq;

   localparam int COLS    = 4;
   localparam int ROWS    = 3;
   localparam int TIMEOUT = 50;
   localparam int ERR_W   = 2;

   logic       clk;
   logic       rst_n;
   logic       pi_flag;
   logic [7:0] pi_data;
   logic       po_flag;
   logic [7:0] po_data;
   logic [1:0] po_col;
   logic [1:0] po_row;
   logic       po_sof;
   logic       po_eof;
   logic       clr;
   logic       busy;
   logic       frame_done;
   logic [1:0] err_cnt;

   int vectors;
   int miscompares;

   sobel_frame_seq #(
      .COLS    (COLS),
      .ROWS    (ROWS),
      .HDR0    (8'hAA),
      .HDR1    (8'h55),
      .TIMEOUT (TIMEOUT),
      .ERR_W   (ERR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pi_flag    (pi_flag),
      .pi_data    (pi_data),
      .po_flag    (po_flag),
      .po_data    (po_data),
      .po_col     (po_col),
      .po_row     (po_row),
      .po_sof     (po_sof),
      .po_eof     (po_eof),
      .clr        (clr),
      .busy       (busy),
      .frame_done (frame_done),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, let the edge pass, sample 1 ns later.
   task automatic cyc(input logic f, input logic [7:0] d);
      pi_flag = f;
      pi_data = d;
      @(posedge clk);
      #1;
      pi_flag = 1'b0;
   endtask

   // Send AA,55 and expect the frame-start clr one cycle after the 55.
   task automatic lock_hdr();
      cyc(1'b1, 8'hAA);
      chk("hdr_busy", 32'(busy), 32'd1);
      chk("hdr_noflag", 32'(po_flag), 32'd0);
      cyc(1'b1, 8'h55);
      chk("lock_clr", 32'(clr), 32'd1);
      chk("lock_busy", 32'(busy), 32'd1);
   endtask

   // One pixel plus a trailing idle cycle.
   task automatic pix(input logic [7:0] d, input int c, input int r);
      cyc(1'b1, d);
      chk("po_flag", 32'(po_flag), 32'd1);
      chk("po_data", 32'(po_data), 32'(d));
      chk("po_col", 32'(po_col), 32'(c));
      chk("po_row", 32'(po_row), 32'(r));
      chk("po_sof", 32'(po_sof), 32'((c == 0) && (r == 0)));
      chk("po_eof", 32'(po_eof), 32'((c == 3) && (r == 2)));
      chk("done_early", 32'(frame_done), 32'd0);
      cyc(1'b0, 8'h00);
      chk("po_flag_low", 32'(po_flag), 32'd0);
      chk("frame_done", 32'(frame_done), 32'((c == 3) && (r == 2)));
   endtask

   task automatic send_frame(input logic [7:0] base);
      for (int i = 0; i < 12; i++) pix(8'(base + i), i % 4, i / 4);
      chk("end_busy", 32'(busy), 32'd0);
      cyc(1'b0, 8'h00);
      chk("done_low", 32'(frame_done), 32'd0);
   endtask

   // Lock a header then stay silent until the DATA timeout aborts.
   task automatic abort_run(input int exp_err);
      cyc(1'b1, 8'hAA);
      cyc(1'b1, 8'h55);
      repeat (50) cyc(1'b0, 8'h00);
      chk("sat_clr_pre", 32'(clr), 32'd0);
      cyc(1'b0, 8'h00);
      chk("sat_clr", 32'(clr), 32'd1);
      chk("sat_err", 32'(err_cnt), 32'(exp_err));
   endtask

   initial begin
      int clr_seen;
      vectors     = 0;
      miscompares = 0;
      rst_n   = 1'b0;
      pi_flag = 1'b0;
      pi_data = 8'h00;

      // Reset state
      cyc(1'b0, 8'h00);
      cyc(1'b0, 8'h00);
      chk("rst_po_flag", 32'(po_flag), 32'd0);
      chk("rst_clr", 32'(clr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      cyc(1'b0, 8'h00);

      // Nominal frame
      lock_hdr();
      cyc(1'b0, 8'h00);
      chk("clr_pulse_end", 32'(clr), 32'd0);
      send_frame(8'h00);
      chk("nom_err", 32'(err_cnt), 32'd0);

      // Header hunt: 12 dropped; AA,AA,34 falls back; AA,55 locks
      cyc(1'b1, 8'h12);
      chk("hunt_idle", 32'(busy), 32'd0);
      cyc(1'b1, 8'hAA);
      chk("hunt_hdr", 32'(busy), 32'd1);
      cyc(1'b1, 8'hAA);
      chk("hunt_aa_stay", 32'(busy), 32'd1);
      cyc(1'b1, 8'h34);
      chk("hunt_drop", 32'(busy), 32'd0);
      chk("hunt_noflag", 32'(po_flag), 32'd0);
      lock_hdr();
      send_frame(8'hA0);

      // Byte lands exactly at the terminal count: processed, no abort
      lock_hdr();
      pix(8'h40, 0, 0);
      repeat (48) cyc(1'b0, 8'h00);
      chk("coll_busy", 32'(busy), 32'd1);
      pix(8'h41, 1, 0);
      chk("coll_busy2", 32'(busy), 32'd1);
      chk("coll_clr", 32'(clr), 32'd0);
      chk("coll_err", 32'(err_cnt), 32'd0);
      for (int i = 2; i < 12; i++) pix(8'(8'h40 + i), i % 4, i / 4);
      cyc(1'b0, 8'h00);

      // Timeout abort after 5 pixels
      lock_hdr();
      for (int i = 0; i < 5; i++) pix(8'(8'h60 + i), i % 4, i / 4);
      repeat (48) cyc(1'b0, 8'h00);
      chk("tmo_busy49", 32'(busy), 32'd1);
      chk("tmo_clr49", 32'(clr), 32'd0);
      cyc(1'b0, 8'h00);
      chk("tmo_abort_busy", 32'(busy), 32'd0);
      chk("tmo_abort_err0", 32'(err_cnt), 32'd0);
      cyc(1'b0, 8'h00);
      chk("tmo_clr", 32'(clr), 32'd1);
      chk("tmo_err", 32'(err_cnt), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd0);
      cyc(1'b0, 8'h00);
      chk("tmo_clr_end", 32'(clr), 32'd0);
      lock_hdr();
      send_frame(8'h80);

      // Saturation: err_cnt goes 2,3,3,3
      abort_run(2);
      abort_run(3);
      abort_run(3);
      abort_run(3);

      // HDR timeout returns to IDLE silently
      clr_seen = 0;
      cyc(1'b1, 8'hAA);
      for (int i = 0; i < 51; i++) begin
         cyc(1'b0, 8'h00);
         if (clr) clr_seen++;
      end
      chk("hdr_tmo_busy", 32'(busy), 32'd0);
      chk("hdr_tmo_clr", 32'(clr_seen), 32'd0);
      chk("hdr_tmo_err", 32'(err_cnt), 32'd3);

      // Reset mid-frame
      lock_hdr();
      for (int i = 0; i < 6; i++) pix(8'(8'h20 + i), i % 4, i / 4);
      rst_n = 1'b0;
      cyc(1'b0, 8'h00);
      chk("mrst_flag", 32'(po_flag), 32'd0);
      chk("mrst_clr", 32'(clr), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_err", 32'(err_cnt), 32'd0);
      chk("mrst_data", 32'(po_data), 32'd0);
      chk("mrst_col", 32'(po_col), 32'd0);
      chk("mrst_row", 32'(po_row), 32'd0);
      rst_n = 1'b1;
      cyc(1'b1, 8'h11);
      chk("mrst_nopix1", 32'(po_flag), 32'd0);
      cyc(1'b1, 8'h22);
      chk("mrst_nopix2", 32'(po_flag), 32'd0);
      chk("mrst_idle", 32'(busy), 32'd0);
      lock_hdr();
      send_frame(8'hC0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
